bm_dag3_arb: RTL and testbench

Round-robin scheduler that shares one pipelined 2-bit DAG datapath among four requesters. Each granted requester's operand pair enters a fixed 3-stage XOR/OR/AND pipeline. The result returns tagged with the requester index. A flush/drain state machine lets the top-level benchmark quiesce the shared resource. The block sits between independent operand sources and the shared DAG compute, in the micro-benchmark suite.

---
 rtl/bm_dag3_pkg.sv | 9 +
 rtl/bm_dag3_arb_if.sv | 24 ++
 rtl/bm_dag3_rr_pick.sv | 30 +++
 rtl/bm_dag3_arb.sv | 101 ++++++++++
 tb/tb_bm_dag3_arb.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bm_dag3_pkg.sv
// Shared constants and FSM state type for the round-robin DAG arbiter.
package bm_dag3_pkg;
  localparam int BITS = 2;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
endpackage

// File: rtl/bm_dag3_arb_if.sv
// Requester/response bundle between operand sources and the DAG arbiter.
interface bm_dag3_arb_if #(
  parameter int BITS = bm_dag3_pkg::BITS,
  parameter int NREQ = bm_dag3_pkg::NREQ
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] a_in;
  logic [NREQ*BITS-1:0] b_in;
  logic                 flush;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 resp_valid;
  logic [IW-1:0]        resp_id;
  logic [BITS-1:0]      resp_data;
  logic                 flush_done;
  logic [7:0]           issue_count;

  modport master (output req, a_in, b_in, flush,
                  input  gnt, busy, resp_valid, resp_id, resp_data, flush_done, issue_count);
  modport slave  (input  req, a_in, b_in, flush,
                  output gnt, busy, resp_valid, resp_id, resp_data, flush_done, issue_count);
endinterface

// File: rtl/bm_dag3_rr_pick.sv
// Cyclic priority picker: first set req bit at or above ptr, wrapping.
module bm_dag3_rr_pick #(
  parameter int NREQ = bm_dag3_pkg::NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic          found;
  logic [IW-1:0] j;

  // NREQ is a power of two, so the IW-bit add wraps the scan for free
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = ptr + IW'(k);
      if (enable && !found && req[j]) begin
        found  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bm_dag3_arb.sv
// Round-robin share of a 3-stage XOR/OR/AND pipeline with flush/drain FSM.
// Define BM_DAG3_ARB_STATS_EN to build the saturating issue counter.
module bm_dag3_arb
  import bm_dag3_pkg::*;
#(
  parameter int BITS = bm_dag3_pkg::BITS,
  parameter int NREQ = bm_dag3_pkg::NREQ,
  parameter int LAT  = bm_dag3_pkg::LAT  // datapath below is hard-wired to 3 stages
) (
  input  logic          clock,
  input  logic          reset,
  bm_dag3_arb_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  state_t                 state, state_n;
  logic                   done_n, flush_done_q;
  logic [IW-1:0]          ptr, pick_idx;
  logic                   issue, post_empty;
  logic [BITS-1:0]        a_sel, b_sel;
  logic [LAT:1]           vld_pipe;
  logic [LAT:1][IW-1:0]   tag_pipe;
  logic [BITS-1:0]        s1_q, a1_q, b1_q, s2_q, a2_q, s3_q;

  bm_dag3_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .enable ((state != DRAIN) && !bus.flush),
    .gnt    (bus.gnt),
    .idx    (pick_idx)
  );

  assign issue = |bus.gnt;
  assign a_sel = bus.a_in[pick_idx*BITS +: BITS];
  assign b_sel = bus.b_in[pick_idx*BITS +: BITS];
  // Pipeline empty after this edge: nothing entering and nothing moving into stage 2/3
  assign post_empty = !issue && !(|vld_pipe[LAT-1:1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      s1_q <= '0; a1_q <= '0; b1_q <= '0;
      s2_q <= '0; a2_q <= '0; s3_q <= '0;
      ptr  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:1], issue};
      tag_pipe <= {tag_pipe[LAT-1:1], pick_idx};
      s1_q <= a_sel ^ b_sel;
      a1_q <= a_sel;
      b1_q <= b_sel;
      s2_q <= s1_q | b1_q;
      a2_q <= a1_q;
      s3_q <= s2_q & a2_q;
      if (issue) ptr <= pick_idx + IW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      flush_done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE:    if (bus.flush) state_n = DRAIN;
               else if (issue) state_n = ACTIVE;
      ACTIVE:  if (bus.flush) state_n = DRAIN;
               else if (post_empty) state_n = IDLE;
      DRAIN:   if (!bus.flush && post_empty) begin
                 state_n = IDLE;
                 done_n  = 1'b1;
               end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = vld_pipe[LAT];
  assign bus.resp_id    = tag_pipe[LAT];
  assign bus.resp_data  = s3_q;
  assign bus.flush_done = flush_done_q;

`ifdef BM_DAG3_ARB_STATS_EN
  logic [7:0] issue_cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              issue_cnt_q <= '0;
    else if (issue && issue_cnt_q != 8'hFF) issue_cnt_q <= issue_cnt_q + 8'd1;
  end
  assign bus.issue_count = issue_cnt_q;
`else
  assign bus.issue_count = 8'd0;
`endif
endmodule

// File: tb/tb_bm_dag3_arb.sv
// Directed bench for bm_dag3_arb: grant order, latency, flush/drain, async reset, stats.
module tb_bm_dag3_arb;
  logic clock, reset;
  int n_cmp = 0;
  int n_bad = 0;

  bm_dag3_arb_if bus ();

  bm_dag3_arb dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.flush  = 1'b0;
    // a slice i = i; result ((a^b)|b)&a reduces to a, so data identifies requester
    bus.a_in   = 8'b11_10_01_00;
    bus.b_in   = 8'b01_11_00_11;
    #3;
    chk("rst_gnt",   bus.gnt, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_vld",   bus.resp_valid, 0);
    chk("rst_id",    bus.resp_id, 0);
    chk("rst_data",  bus.resp_data, 0);
    chk("rst_done",  bus.flush_done, 0);
    chk("rst_cnt",   bus.issue_count, 0);
    tick();
    reset = 1'b0;

    // single issue: a0=10 b0=11 -> 10
    bus.a_in[1:0] = 2'b10;
    bus.req = 4'b0001;
    #1 chk("one_gnt", bus.gnt, 4'b0001);
    tick(); bus.req = '0;
    chk("one_busy", bus.busy, 1);
    chk("one_vld0", bus.resp_valid, 0);
    tick(); chk("one_vld1", bus.resp_valid, 0);
    tick();
    chk("one_vld", bus.resp_valid, 1);
    chk("one_id", bus.resp_id, 0);
    chk("one_data", bus.resp_data, 2'b10);
    chk("one_busy2", bus.busy, 1);
    tick();
    chk("one_idle", bus.busy, 0);
    chk("one_vld_off", bus.resp_valid, 0);

    // round robin, ptr back to 0
    do_reset();
    bus.a_in = 8'b11_10_01_00;
    bus.req  = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) bus.req = '0;
      #1;
      if (k < 8) chk("rr_gnt", bus.gnt, 32'd1 << (k % 4));
      else       chk("rr_gnt_off", bus.gnt, 0);
      if (k >= 3 && k <= 10) begin
        chk("rr_vld", bus.resp_valid, 1);
        chk("rr_id", bus.resp_id, (k - 3) % 4);
        chk("rr_data", bus.resp_data, (k - 3) % 4);
      end else chk("rr_vld_off", bus.resp_valid, 0);
      tick();
    end
    chk("rr_idle", bus.busy, 0);

    // pointer skip: grant 1 -> ptr 2, then 0011 wraps to 0 then 1
    bus.req = 4'b0010;
    #1 chk("skip_g1", bus.gnt, 4'b0010);
    tick(); bus.req = 4'b0011;
    #1 chk("skip_g0", bus.gnt, 4'b0001);
    tick();
    #1 chk("skip_g1b", bus.gnt, 4'b0010);
    tick(); bus.req = '0;
    repeat (4) tick();
    chk("skip_idle", bus.busy, 0);

    // flush drain with three in flight; ptr starts at 2
    bus.req = 4'b1111;
    #1 chk("fl_g2", bus.gnt, 4'b0100);
    tick(); #1 chk("fl_g3", bus.gnt, 4'b1000);
    tick(); #1 chk("fl_g0", bus.gnt, 4'b0001);
    tick(); bus.flush = 1'b1;
    #1 chk("fl_nogrant", bus.gnt, 0);
    chk("fl_r2_vld", bus.resp_valid, 1);
    chk("fl_r2_id", bus.resp_id, 2);
    tick(); bus.flush = 1'b0;
    #1 chk("fl_drain_gnt", bus.gnt, 0);
    chk("fl_drain_busy", bus.busy, 1);
    chk("fl_r3_id", bus.resp_id, 3);
    chk("fl_r3_data", bus.resp_data, 3);
    tick();
    chk("fl_r0_vld", bus.resp_valid, 1);
    chk("fl_r0_id", bus.resp_id, 0);
    chk("fl_done_early", bus.flush_done, 0);
    tick();
    chk("fl_done", bus.flush_done, 1);
    chk("fl_vld_off", bus.resp_valid, 0);
    chk("fl_busy_off", bus.busy, 0);
    chk("fl_resume", bus.gnt, 4'b0010);
    bus.req = '0;
    tick();
    chk("fl_done_pulse", bus.flush_done, 0);

    // flush held on an empty pipe: stay in DRAIN, pulse only on release
    bus.req = 4'b0100; bus.flush = 1'b1;
    #1 chk("hold_gnt", bus.gnt, 0);
    repeat (3) tick();
    chk("hold_busy", bus.busy, 1);
    chk("hold_done", bus.flush_done, 0);
    chk("hold_gnt2", bus.gnt, 0);
    bus.req = '0; bus.flush = 1'b0;
    tick();
    chk("hold_rel_done", bus.flush_done, 1);
    chk("hold_rel_busy", bus.busy, 0);

    // async reset with two in flight; ptr is 1 here
    bus.req = 4'b0011;
    #1 chk("ar_g1", bus.gnt, 4'b0010);
    tick(); #1 chk("ar_g0", bus.gnt, 4'b0001);
    tick(); bus.req = '0;
    tick();
    chk("ar_vld_pre", bus.resp_valid, 1);
    #2 reset = 1'b1;
    #1 chk("ar_vld_now", bus.resp_valid, 0);
    chk("ar_busy_now", bus.busy, 0);
    #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ar_no_resp", bus.resp_valid, 0);
    end
    bus.req = 4'b1111;
    #1 chk("ar_ptr0", bus.gnt, 4'b0001);
    bus.req = '0;
    #1;

    // stats: 300 issues to requester 0
    bus.req = 4'b0001;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 9) begin
`ifdef BM_DAG3_ARB_STATS_EN
        chk("st_cnt10", bus.issue_count, 10);
`else
        chk("st_cnt10", bus.issue_count, 0);
`endif
      end
    end
    bus.req = '0;
    repeat (4) tick();
`ifdef BM_DAG3_ARB_STATS_EN
    chk("st_sat", bus.issue_count, 255);
`else
    chk("st_sat", bus.issue_count, 0);
`endif
    chk("st_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
